// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared defaults and state/source enums for the program store
package cpu_pkg;

    localparam int PS_DATA_W = 4;
    localparam int PS_DEPTH  = 15;
    localparam int PS_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD
    } ps_state_t;

    typedef enum logic [1:0] {
        SRC_CLEAR,
        SRC_DIRECT,
        SRC_LOAD
    } wr_src_t;

endpackage

// File: rtl/prog_store_if.sv
// rtl/prog_store_if.sv - host/core signal bundle for the program store
interface prog_store_if #(
    parameter int DATA_W = cpu_pkg::PS_DATA_W,
    parameter int ADDR_W = cpu_pkg::PS_ADDR_W
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic              busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output load_start, load_valid, load_data, load_last,
        input  rd_data, load_ready, load_done, load_err, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  load_start, load_valid, load_data, load_last,
        output rd_data, load_ready, load_done, load_err, busy
    );
endinterface

// File: rtl/prog_store_array.sv
// rtl/prog_store_array.sv - plain 1W1R synchronous RAM, read returns old data on collision
module prog_store_array #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/prog_store.sv
// rtl/prog_store.sv - program memory with self-clear on reset, direct writes and burst loader
module prog_store
    import cpu_pkg::*;
#(
    parameter int DATA_W = PS_DATA_W,
    parameter int DEPTH  = PS_DEPTH,
    parameter int ADDR_W = PS_ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    prog_store_if.slave bus
);
    generate
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("prog_store: DEPTH must be 1..2**ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    ps_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rd_en_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    wr_src_t           src;

    logic rd_in_range;
    logic wr_in_range;

    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_X;
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_X;
    // Out-of-range reads are zeroed at the output; steer the RAM to a legal row meanwhile.
    assign mem_raddr   = rd_in_range ? bus.rd_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_en_q <= (state_q != ST_CLEAR) && rd_in_range;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        src       = SRC_CLEAR;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end else if (bus.wr_en && wr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.wr_addr;
                    mem_wdata = bus.wr_data;
                    src       = SRC_DIRECT;
                end
            end
            ST_LOAD: begin
                if (bus.load_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.load_data;
                    src       = SRC_LOAD;
                    if (bus.load_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (ptr_q == LAST) begin
                        // Image longer than the store: keep what fit and flag it.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    prog_store_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we & ~rst),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

    assign bus.rd_data    = rd_en_q ? mem_rdata : '0;
    assign bus.load_ready = (state_q == ST_LOAD);
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;
    assign bus.busy       = (state_q != ST_IDLE);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && mem_we && src != SRC_CLEAR) begin
            $display("prog_store write addr=%0d data=%0h src=%s", mem_waddr, mem_wdata,
                     (src == SRC_LOAD) ? "load" : "direct");
        end
    end
`endif
endmodule

// File: tb/tb_prog_store.sv
// tb/tb_prog_store.sv - scoreboard bench for prog_store: clear, direct, burst, overrun, reset abort
module tb_prog_store;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_store_if #(.DATA_W(4), .ADDR_W(4)) bus ();

    prog_store #(.DATA_W(4), .DEPTH(15), .ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [3:0] model [16];
    logic [3:0] exp_q [$];
    logic [3:0] exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.rd_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 4'h0;
    endtask

    task automatic direct_write(input logic [3:0] a, input logic [3:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        if (a < 4'd15) model[a] = d;
    endtask

    task automatic test_reset();
        int n;
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({bus.rd_data, bus.load_ready, bus.load_done, bus.load_err, bus.busy} !== 8'b0000_0001)
            $display("FAIL reset_values got=%b exp=%b",
                     {bus.rd_data, bus.load_ready, bus.load_done, bus.load_err, bus.busy}, 8'b0000_0001);
        else pass_cnt++;
        rst = 1'b0;
        clear_model();
        n = 0;
        while (bus.busy && n < 40) begin tick(); n++; end
        total_cnt++;
        if (n !== 15) $display("FAIL reset_busy_len got=%0d exp=15", n);
        else pass_cnt++;
    endtask

    task automatic test_reset_clear();
        int n;
        int nz;
        direct_write(4'd3, 4'hA);
        bus.rd_addr = 4'd3;
        exp_q.push_back(model[3]);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.rd_data !== exp_v) $display("FAIL preload_read got=%h exp=%h", bus.rd_data, exp_v);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        n  = 0;
        nz = 0;
        while (bus.busy && n < 40) begin
            if (bus.rd_data !== 4'h0) nz++;
            tick();
            n++;
        end
        total_cnt++;
        if (n !== 15) $display("FAIL clear_busy_len got=%0d exp=15", n);
        else pass_cnt++;
        total_cnt++;
        if (nz !== 0) $display("FAIL clear_rd_forced_zero got=%0d nonzero exp=0", nz);
        else pass_cnt++;
        bus.rd_addr = 4'd3;
        exp_q.push_back(model[3]);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.rd_data !== exp_v) $display("FAIL clear_read3 got=%h exp=%h", bus.rd_data, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_direct();
        direct_write(4'd5, 4'h7);
        bus.rd_addr = 4'd5;
        exp_q.push_back(model[5]);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.rd_data !== exp_v) $display("FAIL direct_read got=%h exp=%h", bus.rd_data, exp_v);
        else pass_cnt++;
        // collision: read must see the value before this edge's write
        bus.rd_addr = 4'd5;
        exp_q.push_back(model[5]);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd5;
        bus.wr_data = 4'h9;
        tick();
        bus.wr_en = 1'b0;
        model[5]  = 4'h9;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.rd_data !== exp_v) $display("FAIL collision_old got=%h exp=%h", bus.rd_data, exp_v);
        else pass_cnt++;
        exp_q.push_back(model[5]);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.rd_data !== exp_v) $display("FAIL collision_new got=%h exp=%h", bus.rd_data, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_burst_stall();
        logic       v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] d [5] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h3};
        logic       l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int ptr;
        int done_cnt;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        total_cnt++;
        if ({bus.load_ready, bus.busy, bus.load_err} !== 3'b110)
            $display("FAIL burst_enter got=%b exp=110", {bus.load_ready, bus.busy, bus.load_err});
        else pass_cnt++;
        ptr      = 0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = v[i];
            bus.load_data  = d[i];
            bus.load_last  = l[i];
            if (v[i]) begin model[ptr] = d[i]; ptr++; end
            tick();
            if (bus.load_done) done_cnt++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        total_cnt++;
        if (bus.load_done !== 1'b1) $display("FAIL burst_done_after_last got=%b exp=1", bus.load_done);
        else pass_cnt++;
        tick();
        if (bus.load_done) done_cnt++;
        total_cnt++;
        if ({bus.load_done, bus.busy, bus.load_err} !== 3'b000)
            $display("FAIL burst_after got=%b exp=000", {bus.load_done, bus.busy, bus.load_err});
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL burst_done_count got=%0d exp=1", done_cnt);
        else pass_cnt++;
        for (int a = 0; a < 4; a++) begin
            bus.rd_addr = 4'(a);
            exp_q.push_back(model[a]);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (bus.rd_data !== exp_v) $display("FAIL burst_read addr=%0d got=%h exp=%h", a, bus.rd_data, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        int  bad_ready;
        logic exp_ready;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bad_ready = 0;
        for (int i = 0; i < 16; i++) begin
            exp_ready      = (i < 15);
            bus.load_valid = 1'b1;
            bus.load_data  = 4'(15 - i);
            bus.load_last  = 1'b0;
            if (bus.load_ready !== exp_ready) bad_ready++;
            if (exp_ready) model[i] = 4'(15 - i);
            tick();
            if (i == 14) begin
                total_cnt++;
                if ({bus.load_done, bus.load_err} !== 2'b11)
                    $display("FAIL overrun_flag got=%b exp=11", {bus.load_done, bus.load_err});
                else pass_cnt++;
            end
        end
        bus.load_valid = 1'b0;
        total_cnt++;
        if (bad_ready !== 0) $display("FAIL overrun_ready got=%0d bad beats exp=0", bad_ready);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({bus.load_done, bus.load_err, bus.busy} !== 3'b010)
            $display("FAIL overrun_sticky got=%b exp=010", {bus.load_done, bus.load_err, bus.busy});
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            exp_q.push_back(model[a]);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (bus.rd_data !== exp_v) $display("FAIL overrun_read addr=%0d got=%h exp=%h", a, bus.rd_data, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] addrs [3] = '{4'd0, 4'd4, 4'd6};
        direct_write(4'd15, 4'hF);
        bus.rd_addr = 4'd15;
        exp_q.push_back(model[15]);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.rd_data !== exp_v) $display("FAIL oor_read15 got=%h exp=%h", bus.rd_data, exp_v);
        else pass_cnt++;
        bus.load_start = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 4'd4;
        bus.wr_data    = 4'hE;
        tick();
        bus.load_start = 1'b0;
        total_cnt++;
        if ({bus.load_err, bus.load_ready} !== 2'b01)
            $display("FAIL start_clears_err got=%b exp=01", {bus.load_err, bus.load_ready});
        else pass_cnt++;
        bus.wr_addr    = 4'd6;
        bus.wr_data    = 4'hD;
        bus.load_valid = 1'b1;
        bus.load_data  = 4'h5;
        bus.load_last  = 1'b1;
        model[0]       = 4'h5;
        tick();
        bus.wr_en      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        tick();
        foreach (addrs[k]) begin
            bus.rd_addr = addrs[k];
            exp_q.push_back(model[addrs[k]]);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (bus.rd_data !== exp_v)
                $display("FAIL load_ignores_wr addr=%0d got=%h exp=%h", addrs[k], bus.rd_data, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        int done_seen;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 4'(6 + i);
            tick();
            if (bus.load_done) done_seen++;
        end
        bus.load_data = 4'h8;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.load_valid = 1'b0;
        clear_model();
        if (bus.load_done) done_seen++;
        total_cnt++;
        if ({bus.load_err, bus.busy, bus.load_ready} !== 3'b010)
            $display("FAIL abort_state got=%b exp=010", {bus.load_err, bus.busy, bus.load_ready});
        else pass_cnt++;
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
            if (bus.load_done) done_seen++;
        end
        total_cnt++;
        if (n !== 15) $display("FAIL abort_busy_len got=%0d exp=15", n);
        else pass_cnt++;
        total_cnt++;
        if (done_seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_seen);
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            exp_q.push_back(model[a]);
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (bus.rd_data !== exp_v) $display("FAIL abort_read addr=%0d got=%h exp=%h", a, bus.rd_data, exp_v);
            else pass_cnt++;
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_reset_clear();
        test_direct();
        test_burst_stall();
        test_overrun();
        test_out_of_range();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/prog_store.md
Name: prog_store

Overview:
- Parametrised program memory with a built-in streaming loader.
- Replaces the fixed 15x4 program memory.
- Holds the CPU program image. The core reads it through a registered-address read port.
- A host/testbench fills it either by direct single-word writes or by a valid/ready burst loader that auto-increments the address.
- On reset the block clears itself word by word; stale images cannot survive a reset.

Parameters:
- DATA_W, 4, word width in bits
- DEPTH, 15, number of words; legal addresses 0..DEPTH-1
- ADDR_W, 4, address width; DEPTH <= 2**ADDR_W required, elaboration error otherwise

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  ADDR_W  core read address
- rd_data  out  DATA_W  registered read data, 1-cycle latency
- wr_en  in  1  direct write strobe
- wr_addr  in  ADDR_W  direct write address
- wr_data  in  DATA_W  direct write data
- load_start  in  1  begin burst load at address 0
- load_valid  in  1  load beat valid
- load_data  in  DATA_W  load beat data
- load_last  in  1  marks final beat of burst
- load_ready  out  1  loader accepts a beat this cycle
- load_done  out  1  one-cycle pulse at end of burst
- load_err  out  1  sticky: burst overran DEPTH; cleared by next load_start or rst
- busy  out  1  high in CLEAR or LOAD

Behaviour:
- Reset values:
  - rd_data=0, load_ready=0, load_done=0, load_err=0, busy=1.
  - FSM=CLEAR, pointer=0.
- FSM states: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle, then ptr++.
  - After the write to ptr=DEPTH-1, go to IDLE with busy=0. This takes exactly DEPTH cycles after rst deasserts.
  - rd_data is forced to 0 throughout.
  - wr_en and load_start are ignored.
- IDLE:
  - busy=0, load_ready=0.
  - wr_en with wr_addr<DEPTH writes mem[wr_addr]<=wr_data. wr_addr>=DEPTH is ignored.
  - load_start=1 goes to LOAD, sets ptr=0 and clears load_err. wr_en in the same cycle is ignored.
- LOAD:
  - load_ready=1 and busy=1. wr_en is ignored.
  - A beat is accepted when load_valid & load_ready. On acceptance: mem[ptr]<=load_data, then ptr++.
  - Accepted beat with load_last=1: write it, pulse load_done for the next cycle, go to IDLE.
  - Accepted beat at ptr=DEPTH-1 with load_last=0: write it, set load_err, pulse load_done, go to IDLE. Any further beats see load_ready=0.
  - load_start while in LOAD is ignored.
- Read port:
  - Every cycle outside CLEAR: rd_data <= (rd_addr<DEPTH) ? mem[rd_addr] : 0.
  - Reads are allowed in all non-CLEAR states, including during LOAD.
  - Read/write collision on the same address in the same cycle returns the OLD data. The new data is visible on the next read.
- Writes take effect at the clock edge and are readable one cycle later.
- Reset mid-LOAD or mid-CLEAR:
  - Abort, ptr=0, restart CLEAR.
  - No load_done pulse. load_err cleared.
- ptr width is ADDR_W and never wraps. Termination is by DEPTH compare, not overflow.
- Simulation-only $display on every committed write: address, data, source (direct/load/clear, clear optional).

Decomposition:
- Shared package cpu_pkg:
  - Default DATA_W/ADDR_W/DEPTH constants.
  - State enum {ST_CLEAR, ST_IDLE, ST_LOAD}.
- One natural sub-module, prog_store_array:
  - Plain 1W1R synchronous RAM, read-old-on-collision.
  - Ports clk, we, waddr, wdata, raddr, rdata.
  - Easy to swap for a vendor macro later.
- Write-port mux (clear/load/direct) and FSM stay in prog_store.

Test Plan:
- Reset clear: preload mem via direct writes (addr 3 = 4'hA), pulse rst 1 cycle.
  - busy=1 for exactly 15 cycles, then 0.
  - rd_addr=3 gives rd_data=0 one cycle after busy falls.
- Direct write/read: wr_en addr 5 data 4'h7, next cycle rd_addr=5 -> rd_data=4'h7 one cycle later.
  - Same-cycle write 4'h9 to addr 5 with rd_addr=5 -> rd_data=4'h7, then 4'h9 on the following read.
- Burst load with stalls: load_start, then beats 1,2,3 (last on 3) with load_valid low for 2 cycles between beats 1 and 2.
  - mem[0..2]=1,2,3.
  - load_done pulses once, load_err=0, busy drops the cycle after done.
- Overrun: load 16 beats with no load_last.
  - Beats 0..14 written.
  - load_err=1 and load_done pulse after beat 15 (index 14).
  - load_ready=0 for the 16th beat; mem unchanged by it.
  - load_err stays 1 until next load_start.
- Out-of-range: wr_en addr 15 data 4'hF -> no write. rd_addr=15 -> rd_data=0.
  - wr_en during LOAD -> ignored.
- Reset mid-LOAD: rst after 2 accepted beats.
  - No load_done, CLEAR restarts (busy high 15 cycles).
  - Afterwards all reads return 0.
